// File: rtl/crossing_scheduler_if.sv
// -----------------------------------------------------------------------------
// crossing_scheduler_if
//
// Bundles the crossing scheduler's control inputs and light outputs.
//
// Signals:
//   tick       - one-cycle strobe per blink period (from the blinker)
//   pedReq     - one-cycle strobe from the debounced pedestrian button
//   mode       - level: 0 normal cycling, 1 night flashing
//   lightA     - road A light code (0 red, 1 green, 2 yellow, 3 off)
//   lightB     - road B light code, same encoding
//   walk       - pedestrian walk indication
//   pedPending - latched pedestrian request not yet served
//   phase      - current scheduler state code (debug / LED display)
//
// Modports:
//   master - the side producing tick/pedReq/mode and consuming the lights
//   slave  - the scheduler itself
// -----------------------------------------------------------------------------
interface crossing_scheduler_if;
    logic       tick;
    logic       pedReq;
    logic       mode;
    logic [1:0] lightA;
    logic [1:0] lightB;
    logic       walk;
    logic       pedPending;
    logic [2:0] phase;

    modport master (
        output tick,
        output pedReq,
        output mode,
        input  lightA,
        input  lightB,
        input  walk,
        input  pedPending,
        input  phase
    );

    modport slave (
        input  tick,
        input  pedReq,
        input  mode,
        output lightA,
        output lightB,
        output walk,
        output pedPending,
        output phase
    );
endinterface

// File: rtl/crossing_scheduler.sv
// -----------------------------------------------------------------------------
// crossing_scheduler
//
// Phase sequencer for a two-way road crossing with one pedestrian crossing.
// Road A, road B and pedestrian walk requests share the crossing; every state
// is timed by one down-counter measured in blink ticks. A night mode flashes
// both roads yellow.
//
// Ports:
//   sysClk  - system clock, all logic on the rising edge
//   sysRstb - asynchronous active-low reset, released on the next rising edge
//   bus     - crossing_scheduler_if.slave (tick, pedReq, mode in;
//             lightA, lightB, walk, pedPending, phase out)
//
// Input semantics: tick and pedReq are strobes sampled on every rising edge
// they are high; there is no edge detection, so a tick held high for k cycles
// counts as k ticks. mode is a level and is acted on in the cycle it is seen.
// -----------------------------------------------------------------------------
module crossing_scheduler #(
    parameter int C_INT_GREEN  = 10,
    parameter int C_INT_YELLOW = 2,
    parameter int C_INT_CLEAR  = 1,
    parameter int C_INT_WALK   = 5,
    parameter int C_CNT_W      = 8
) (
    input  logic                   sysClk,
    input  logic                   sysRstb,
    crossing_scheduler_if.slave    bus
);

    typedef enum logic [2:0] {
        ALL_RED  = 3'd0,
        GREEN_A  = 3'd1,
        YELLOW_A = 3'd2,
        GREEN_B  = 3'd3,
        YELLOW_B = 3'd4,
        WALK     = 3'd5,
        FLASH    = 3'd6
    } state_t;

    localparam logic [1:0] L_RED    = 2'd0;
    localparam logic [1:0] L_GREEN  = 2'd1;
    localparam logic [1:0] L_YELLOW = 2'd2;
    localparam logic [1:0] L_OFF    = 2'd3;

    // Interval reload values. An interval of 0 behaves as 1 so every state
    // lasts at least one tick and the counter never has to wrap.
    localparam logic [C_CNT_W-1:0] LD_GREEN  = C_CNT_W'((C_INT_GREEN  < 1) ? 1 : C_INT_GREEN);
    localparam logic [C_CNT_W-1:0] LD_YELLOW = C_CNT_W'((C_INT_YELLOW < 1) ? 1 : C_INT_YELLOW);
    localparam logic [C_CNT_W-1:0] LD_CLEAR  = C_CNT_W'((C_INT_CLEAR  < 1) ? 1 : C_INT_CLEAR);
    localparam logic [C_CNT_W-1:0] LD_WALK   = C_CNT_W'((C_INT_WALK   < 1) ? 1 : C_INT_WALK);
    localparam logic [C_CNT_W-1:0] CNT_ONE   = C_CNT_W'(1);

    state_t             state;
    logic [C_CNT_W-1:0] cnt;
    logic               nextDir;     // 0: road A gets the next green, 1: road B
    logic               walkDone;    // a walk already ran in this clearance
    logic               flashPh;     // 0: yellow, 1: off while flashing
    logic               pedPending;

    logic               expire;

    // The tick that sees cnt == 1 is the last tick of the current state.
    assign expire = bus.tick && (cnt == CNT_ONE);

    // -------------------------------------------------------------------------
    // State machine and interval counter
    // -------------------------------------------------------------------------
    always_ff @(posedge sysClk or negedge sysRstb) begin
        if (!sysRstb) begin
            state      <= ALL_RED;
            cnt        <= LD_CLEAR;
            nextDir    <= 1'b0;
            walkDone   <= 1'b0;
            flashPh    <= 1'b0;
            pedPending <= 1'b0;
        end else begin
            // Requests are latched anywhere but WALK; the WALK-entry clear
            // further down overrides a request arriving on that same edge.
            if (bus.pedReq && (state != WALK)) begin
                pedPending <= 1'b1;
            end

            // Timed states count down on each tick; transitions below reload.
            if (bus.tick && (state != FLASH)) begin
                cnt <= cnt - 1'b1;
            end

            case (state)
                GREEN_A: begin
                    // Night mode cuts the green short without waiting for a tick.
                    if (bus.mode || expire) begin
                        state <= YELLOW_A;
                        cnt   <= LD_YELLOW;
                    end
                end

                YELLOW_A: begin
                    if (expire) begin
                        state   <= ALL_RED;
                        cnt     <= LD_CLEAR;
                        nextDir <= 1'b1;
                    end
                end

                GREEN_B: begin
                    if (bus.mode || expire) begin
                        state <= YELLOW_B;
                        cnt   <= LD_YELLOW;
                    end
                end

                YELLOW_B: begin
                    if (expire) begin
                        state   <= ALL_RED;
                        cnt     <= LD_CLEAR;
                        nextDir <= 1'b0;
                    end
                end

                ALL_RED: begin
                    if (expire) begin
                        if (bus.mode) begin
                            state   <= FLASH;
                            cnt     <= LD_CLEAR;
                            flashPh <= 1'b0;
                        end else if (pedPending && !walkDone) begin
                            state      <= WALK;
                            cnt        <= LD_WALK;
                            pedPending <= 1'b0;
                        end else begin
                            // walkDone only guards one clearance; a road
                            // green re-arms the pedestrian phase.
                            state    <= nextDir ? GREEN_B : GREEN_A;
                            cnt      <= LD_GREEN;
                            walkDone <= 1'b0;
                        end
                    end
                end

                WALK: begin
                    // Back through ALL_RED with walkDone set, so the road that
                    // was due still gets its green before another walk.
                    if (expire) begin
                        state    <= ALL_RED;
                        cnt      <= LD_CLEAR;
                        walkDone <= 1'b1;
                    end
                end

                FLASH: begin
                    if (!bus.mode) begin
                        state   <= ALL_RED;
                        cnt     <= LD_CLEAR;
                        flashPh <= 1'b0;
                    end else if (bus.tick) begin
                        flashPh <= ~flashPh;
                    end
                end

                default: begin
                    state <= ALL_RED;
                    cnt   <= LD_CLEAR;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode from registered state
    // -------------------------------------------------------------------------
    logic [1:0] lightAComb;
    logic [1:0] lightBComb;
    logic       walkComb;

    always_comb begin
        lightAComb = L_RED;
        lightBComb = L_RED;
        walkComb   = 1'b0;
        case (state)
            GREEN_A:  lightAComb = L_GREEN;
            YELLOW_A: lightAComb = L_YELLOW;
            GREEN_B:  lightBComb = L_GREEN;
            YELLOW_B: lightBComb = L_YELLOW;
            WALK:     walkComb   = 1'b1;
            FLASH: begin
                lightAComb = flashPh ? L_OFF : L_YELLOW;
                lightBComb = flashPh ? L_OFF : L_YELLOW;
            end
            default: begin
                lightAComb = L_RED;
                lightBComb = L_RED;
            end
        endcase
    end

    assign bus.lightA     = lightAComb;
    assign bus.lightB     = lightBComb;
    assign bus.walk       = walkComb;
    assign bus.pedPending = pedPending;
    assign bus.phase      = state;

endmodule

// File: tb/tb_crossing_scheduler.sv
// -----------------------------------------------------------------------------
// tb_crossing_scheduler
//
// Directed bench for crossing_scheduler. Main instance: GREEN=3, YELLOW=1,
// CLEAR=1, WALK=2, tick every 4 clocks. Second instance: YELLOW=0 with tick
// held high continuously.
// -----------------------------------------------------------------------------
module tb_crossing_scheduler;

    // ---------------------------------------------------------------- clock/reset
    logic sysClk;
    logic clkEn;
    logic sysRstb;
    logic rstb0;

    initial begin
        sysClk = 1'b0;
        clkEn  = 1'b1;
        forever begin
            #5;
            if (clkEn) sysClk = ~sysClk;
        end
    end

    crossing_scheduler_if bus  ();
    crossing_scheduler_if bus0 ();

    crossing_scheduler #(
        .C_INT_GREEN (3),
        .C_INT_YELLOW(1),
        .C_INT_CLEAR (1),
        .C_INT_WALK  (2),
        .C_CNT_W     (8)
    ) dut (
        .sysClk (sysClk),
        .sysRstb(sysRstb),
        .bus    (bus.slave)
    );

    crossing_scheduler #(
        .C_INT_GREEN (3),
        .C_INT_YELLOW(0),
        .C_INT_CLEAR (1),
        .C_INT_WALK  (2),
        .C_CNT_W     (8)
    ) dut0 (
        .sysClk (sysClk),
        .sysRstb(rstb0),
        .bus    (bus0.slave)
    );

    // ---------------------------------------------------------------- scoreboard
    int         n_cmp;
    int         n_err;
    logic [2:0] exp_q[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference light code for a road in a non-flash phase.
    function automatic int exp_light(input logic [2:0] ph, input bit roadB);
        int v;
        v = 0;
        case (ph)
            3'd1: v = roadB ? 0 : 1;
            3'd2: v = roadB ? 0 : 2;
            3'd3: v = roadB ? 1 : 0;
            3'd4: v = roadB ? 2 : 0;
            default: v = 0;
        endcase
        return v;
    endfunction

    // ---------------------------------------------------------------- drivers
    // n blink periods of 4 clocks; the tick sits in the first cycle of each.
    task automatic blink(input int n, input logic pedOnTick);
        repeat (n) begin
            @(negedge sysClk);
            bus.tick   = 1'b1;
            bus.pedReq = pedOnTick;
            @(negedge sysClk);
            bus.tick   = 1'b0;
            bus.pedReq = 1'b0;
            repeat (2) @(negedge sysClk);
        end
    endtask

    task automatic pulse_ped();
        @(negedge sysClk);
        bus.pedReq = 1'b1;
        @(negedge sysClk);
        bus.pedReq = 1'b0;
    endtask

    task automatic set_mode(input logic v);
        @(negedge sysClk);
        bus.mode = v;
        @(negedge sysClk);
    endtask

    task automatic check_phase(input string tag, input int ph);
        check_eq(tag, int'(bus.phase), ph);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        logic [2:0] seq[11];
        logic [2:0] e;

        n_cmp       = 0;
        n_err       = 0;
        sysRstb     = 1'b0;
        rstb0       = 1'b0;
        bus.tick    = 1'b0;
        bus.pedReq  = 1'b0;
        bus.mode    = 1'b0;
        bus0.tick   = 1'b0;
        bus0.pedReq = 1'b0;
        bus0.mode   = 1'b0;
        seq = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd0, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0, 3'd1};

        // Reset state
        repeat (2) @(negedge sysClk);
        check_eq("rst_phase",  int'(bus.phase), 0);
        check_eq("rst_lightA", int'(bus.lightA), 0);
        check_eq("rst_lightB", int'(bus.lightB), 0);
        check_eq("rst_walk",   int'(bus.walk), 0);
        check_eq("rst_ped",    int'(bus.pedPending), 0);
        check_eq("rst0_phase", int'(bus0.phase), 0);
        sysRstb = 1'b1;

        // 1: normal cycling, 10-tick period
        for (int i = 0; i < 11; i++) exp_q.push_back(seq[i]);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            blink(1, 1'b0);
            check_eq("t1_phase",  int'(bus.phase), int'(e));
            check_eq("t1_lightA", int'(bus.lightA), exp_light(e, 1'b0));
            check_eq("t1_lightB", int'(bus.lightB), exp_light(e, 1'b1));
            check_eq("t1_excl",   int'((bus.lightA != 2'd0) && (bus.lightB != 2'd0)), 0);
        end

        // 2: pedestrian request during GREEN_A
        pulse_ped();
        check_eq("t2_pend_set", int'(bus.pedPending), 1);
        blink(2, 1'b0);  check_phase("t2_greenA", 1);
        blink(1, 1'b0);  check_phase("t2_yellowA", 2);
        blink(1, 1'b0);  check_phase("t2_clear", 0);
        blink(1, 1'b0);  check_phase("t2_walk", 5);
        check_eq("t2_walk_on",  int'(bus.walk), 1);
        check_eq("t2_walk_lA",  int'(bus.lightA), 0);
        check_eq("t2_walk_lB",  int'(bus.lightB), 0);
        check_eq("t2_pend_clr", int'(bus.pedPending), 0);
        blink(1, 1'b0);  check_phase("t2_walk2", 5);
        blink(1, 1'b0);  check_phase("t2_clear2", 0);
        check_eq("t2_walk_off", int'(bus.walk), 0);
        blink(1, 1'b0);  check_phase("t2_greenB", 3);

        // Advance to the next GREEN_A
        blink(3, 1'b0);  check_phase("adv_yellowB", 4);
        blink(1, 1'b0);  check_phase("adv_clear", 0);
        blink(1, 1'b0);  check_phase("adv_greenA", 1);

        // 3: request on the WALK-entry edge and again mid-WALK
        pulse_ped();
        check_eq("t3_pend_set", int'(bus.pedPending), 1);
        blink(3, 1'b0);  check_phase("t3_yellowA", 2);
        blink(1, 1'b0);  check_phase("t3_clear", 0);
        blink(1, 1'b1);  check_phase("t3_walk", 5);
        check_eq("t3_pend_entry", int'(bus.pedPending), 0);
        pulse_ped();
        check_eq("t3_pend_mid", int'(bus.pedPending), 0);
        blink(1, 1'b0);  check_phase("t3_walk2", 5);
        blink(1, 1'b0);  check_phase("t3_clear2", 0);
        check_eq("t3_pend_after", int'(bus.pedPending), 0);
        blink(1, 1'b0);  check_phase("t3_greenB", 3);

        // 4: night mode from GREEN_B
        set_mode(1'b1);
        check_phase("t4_yellowB_now", 4);
        blink(1, 1'b0);  check_phase("t4_clear", 0);
        blink(1, 1'b0);  check_phase("t4_flash", 6);
        check_eq("t4_fl0_A", int'(bus.lightA), 2);
        check_eq("t4_fl0_B", int'(bus.lightB), 2);
        check_eq("t4_fl0_w", int'(bus.walk), 0);
        blink(1, 1'b0);
        check_eq("t4_fl1_A", int'(bus.lightA), 3);
        check_eq("t4_fl1_B", int'(bus.lightB), 3);
        blink(1, 1'b0);
        check_eq("t4_fl2_A", int'(bus.lightA), 2);
        check_eq("t4_fl2_B", int'(bus.lightB), 2);
        set_mode(1'b0);
        check_phase("t4_exit_clear", 0);
        check_eq("t4_exit_lA", int'(bus.lightA), 0);
        blink(1, 1'b0);  check_phase("t4_greenA", 1);

        // 5: asynchronous reset mid-WALK with the clock stopped
        pulse_ped();
        blink(3, 1'b0);  check_phase("t5_yellowA", 2);
        blink(1, 1'b0);  check_phase("t5_clear", 0);
        blink(1, 1'b0);  check_phase("t5_walk", 5);
        clkEn = 1'b0;
        #2;
        sysRstb = 1'b0;
        #1;
        check_eq("t5_rst_phase",  int'(bus.phase), 0);
        check_eq("t5_rst_lightA", int'(bus.lightA), 0);
        check_eq("t5_rst_lightB", int'(bus.lightB), 0);
        check_eq("t5_rst_walk",   int'(bus.walk), 0);
        check_eq("t5_rst_ped",    int'(bus.pedPending), 0);
        #5;
        sysRstb = 1'b1;
        clkEn   = 1'b1;
        @(negedge sysClk);
        blink(1, 1'b0);  check_phase("t5_first_green", 1);
        check_eq("t5_green_lA", int'(bus.lightA), 1);

        // 6: zero yellow interval with tick held high
        @(negedge sysClk);
        bus0.tick = 1'b1;
        rstb0     = 1'b1;
        for (int i = 0; i < 11; i++) exp_q.push_back(seq[i]);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge sysClk);
            check_eq("t6_phase", int'(bus0.phase), int'(e));
        end
        bus0.tick = 1'b0;

        // ------------------------------------------------------------ report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
